// File: rtl/regfile_wr_demux.sv
// Write-back register bank: registered one-hot write decode feeding a one-entry pending stage,
// plus two combinational read ports with same-cycle and pending-stage forwarding.
module regfile_wr_demux #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic [NUM_REGS-1:0] wr_onehot,
    output logic                wr_err
);

    localparam logic [ADDR_W:0]   NumRegsW = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] ZeroRegA = ADDR_W'(ZERO_REG);

    logic                wr_in_range;
    logic                wr_ok;
    logic [NUM_REGS-1:0] pend_onehot_d, pend_onehot_q;
    logic [DATA_W-1:0]   pend_data_q;
    logic                wr_err_d, wr_err_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    assign wr_in_range = {1'b0, wr_addr} < NumRegsW;
    assign wr_ok       = wr_en && wr_in_range && (wr_addr != ZeroRegA);
    assign wr_err_d    = wr_en && !wr_in_range;

    // The pending stage holds the decoded one-hot, so its OR is the pending-valid flag.
    always_comb begin
        pend_onehot_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                pend_onehot_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_onehot_q <= '0;
            pend_data_q   <= '0;
            wr_err_q      <= 1'b0;
        end else begin
            pend_onehot_q <= pend_onehot_d;
            pend_data_q   <= wr_data;
            wr_err_q      <= wr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (!reset_n) begin
                regs_q[i] <= '0;
            end else if (pend_onehot_q[i]) begin
                regs_q[i] <= pend_data_q;
            end
        end
    end

    assign wr_onehot = pend_onehot_q;
    assign wr_err    = wr_err_q;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              in_range;
        logic              is_zero;
        logic              fwd_hit;
        logic              pend_hit;
        logic [DATA_W-1:0] arr_data;
        logic [DATA_W-1:0] data;

        assign addr = (p == 0) ? rd_addr1 : rd_addr2;

        always_comb begin
            in_range = {1'b0, addr} < NumRegsW;
            is_zero  = addr == ZeroRegA;
            fwd_hit  = wr_ok && (wr_addr == addr);
            pend_hit = 1'b0;
            arr_data = '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (addr == ADDR_W'(i)) begin
                    pend_hit = pend_onehot_q[i];
                    arr_data = regs_q[i];
                end
            end
            // Youngest value wins: incoming write, then pending entry, then the array.
            if (is_zero || !in_range) begin
                data = '0;
            end else if (fwd_hit) begin
                data = wr_data;
            end else if (pend_hit) begin
                data = pend_data_q;
            end else begin
                data = arr_data;
            end
        end
    end

    assign rd_data1 = g_rd[0].data;
    assign rd_data2 = g_rd[1].data;

endmodule

// File: tb/tb_regfile_wr_demux.sv
// Bench for regfile_wr_demux: full-size and 24-entry instances driven in lockstep against
// an architectural model, plus directed scenarios with literal expectations.
module tb_regfile_wr_demux;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [63:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic [31:0] a_oh;
    logic [23:0] b_oh;
    logic        a_err, b_err;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    regfile_wr_demux u_dut_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (a_rd1),
        .rd_data2 (a_rd2),
        .wr_onehot(a_oh),
        .wr_err   (a_err)
    );

    regfile_wr_demux #(
        .NUM_REGS(24)
    ) u_dut_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (b_rd1),
        .rd_data2 (b_rd2),
        .wr_onehot(b_oh),
        .wr_err   (b_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: committed array, one in-flight write, error flag (index 0 = A, 1 = B).
    logic [63:0] m_regs [2][32];
    logic        m_pv  [2];
    logic [4:0]  m_pa  [2];
    logic [63:0] m_pd  [2];
    logic        m_err [2];

    function automatic int nregs(input int k);
        return (k == 0) ? 32 : 24;
    endfunction

    function automatic logic [63:0] m_read(input int k, input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (int'(a) >= nregs(k)) return 64'd0;
        if (wr_en && wr_addr == a) return wr_data;
        if (m_pv[k] && m_pa[k] == a) return m_pd[k];
        return m_regs[k][a];
    endfunction

    function automatic logic [63:0] m_onehot(input int k);
        return m_pv[k] ? (64'd1 << m_pa[k]) : 64'd0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                for (int i = 0; i < 32; i++) m_regs[k][i] <= 64'd0;
                m_pv[k]  <= 1'b0;
                m_err[k] <= 1'b0;
            end else begin
                if (m_pv[k]) m_regs[k][m_pa[k]] <= m_pd[k];
                m_pv[k]  <= wr_en && wr_addr != 5'd31 && int'(wr_addr) < nregs(k);
                m_pa[k]  <= wr_addr;
                m_pd[k]  <= wr_data;
                m_err[k] <= wr_en && int'(wr_addr) >= nregs(k);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_a_rd1", a_rd1, m_read(0, rd_addr1));
            chk("model_a_rd2", a_rd2, m_read(0, rd_addr2));
            chk("model_b_rd1", b_rd1, m_read(1, rd_addr1));
            chk("model_b_rd2", b_rd2, m_read(1, rd_addr2));
            chk("model_a_onehot", {32'd0, a_oh}, m_onehot(0));
            chk("model_b_onehot", {40'd0, b_oh}, m_onehot(1));
            chk("model_a_err", {63'd0, a_err}, {63'd0, m_err[0]});
            chk("model_b_err", {63'd0, b_err}, {63'd0, m_err[1]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick_addr();
        logic [4:0] hot [6];
        hot = '{5'd5, 5'd7, 5'd9, 5'd23, 5'd28, 5'd31};
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 31));
        return hot[$urandom_range(0, 5)];
    endfunction

    initial begin
        reset_n  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 64'd0;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        tick();
        tick();
        reset_n = 1'b1;
        chk_on  = 1'b1;

        // Everything reads zero after reset.
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            @(negedge clk);
            chk("rst_rd1", a_rd1, 64'd0);
            chk("rst_rd2", a_rd2, 64'd0);
            chk("rst_onehot", {32'd0, a_oh}, 64'd0);
            chk("rst_err", {63'd0, a_err}, 64'd0);
            tick();
        end

        // Write 5: forward, pending, then array.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF;
        rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("w5_rd1", a_rd1, 64'hDEAD_BEEF);
            chk("w5_rd2", a_rd2, 64'hDEAD_BEEF);
            chk("w5_onehot", {32'd0, a_oh}, (c == 1) ? 64'h20 : 64'd0);
            tick();
            wr_en = 1'b0;
        end

        // Write to the zero register is dropped silently.
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h1234; rd_addr1 = 5'd31;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("w31_rd1", a_rd1, 64'd0);
            chk("w31_onehot", {32'd0, a_oh}, 64'd0);
            chk("w31_err", {63'd0, a_err}, 64'd0);
            tick();
            wr_en = 1'b0;
        end

        // Out-of-range write on the 24-entry instance.
        wr_en = 1'b1; wr_addr = 5'd28; wr_data = 64'h55; rd_addr1 = 5'd28;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("oor_rd1", b_rd1, 64'd0);
            chk("oor_err", {63'd0, b_err}, (c == 1) ? 64'd1 : 64'd0);
            chk("oor_onehot", {40'd0, b_oh}, 64'd0);
            tick();
            wr_en = 1'b0;
        end

        // Back-to-back writes to 7.
        rd_addr1 = 5'd7;
        for (int c = 0; c < 3; c++) begin
            wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'(c + 1);
            @(negedge clk);
            chk("b2b_rd1", a_rd1, 64'(c + 1));
            tick();
        end
        wr_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("b2b_final", a_rd1, 64'd3);
            tick();
        end

        // Reset discards a pending write.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hAA; rd_addr1 = 5'd9;
        tick();
        wr_en = 1'b0; reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstpend_rd1", a_rd1, 64'd0);
            chk("rstpend_onehot", {32'd0, a_oh}, 64'd0);
            tick();
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            wr_en    = ($urandom_range(0, 3) != 0);
            wr_addr  = pick_addr();
            wr_data  = {$urandom, $urandom};
            rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr : pick_addr();
            rd_addr2 = pick_addr();
            reset_n  = ($urandom_range(0, 63) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
